// File: rtl/crc_receiver.sv
// Receive-side CRC-4 (x^4+x+1) checker and single-bit corrector for 15-bit frames.
// Syndrome is computed serially MSB first; a nonzero syndrome is located by stepping x^idx mod g.
module crc_receiver (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] data_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] data_out,
  output logic [3:0]  syndrome,
  output logic        crc_ok,
  output logic        corrected,
  output logic [3:0]  err_pos,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, CALC, LOCATE, OUT} state_t;

  state_t      state;
  logic [14:0] frame;
  logic [3:0]  rem;
  logic [3:0]  syn;
  logic [3:0]  t;
  logic [3:0]  cnt;
  logic [3:0]  idx;

  logic        bit_in;
  logic [3:0]  rem_next;
  logic [3:0]  t_next;
  logic [14:0] fixed;

  always_comb begin
    bit_in   = frame[4'd14 - cnt];
    rem_next = {rem[2:0], bit_in} ^ (rem[3] ? 4'b0011 : 4'b0000);
    t_next   = {t[2:0], 1'b0} ^ (t[3] ? 4'b0011 : 4'b0000);
    fixed    = frame ^ (15'd1 << idx);
  end

  // in_ready is combinational so it is low during reset and high right after release.
  assign in_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      frame     <= '0;
      rem       <= '0;
      syn       <= '0;
      t         <= '0;
      cnt       <= '0;
      idx       <= '0;
      data_out  <= '0;
      syndrome  <= '0;
      crc_ok    <= 1'b0;
      corrected <= 1'b0;
      err_pos   <= '0;
      out_valid <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            frame <= data_in;
            rem   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end

        CALC: begin
          rem <= rem_next;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd14) begin
            if (rem_next == 4'd0) begin
              data_out  <= frame[14:4];
              syndrome  <= 4'd0;
              crc_ok    <= 1'b1;
              corrected <= 1'b0;
              err_pos   <= 4'd0;
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              syn   <= rem_next;
              t     <= 4'b0001;
              idx   <= 4'd0;
              state <= LOCATE;
            end
          end
        end

        LOCATE: begin
          if (t == syn) begin
            frame     <= fixed;
            data_out  <= fixed[14:4];
            syndrome  <= syn;
            crc_ok    <= 1'b0;
            corrected <= 1'b1;
            err_pos   <= idx;
            out_valid <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            state     <= OUT;
          end else if (idx == 4'd14) begin
            // Unreachable with a primitive generator; emit uncorrected rather than spin.
            data_out  <= frame[14:4];
            syndrome  <= syn;
            crc_ok    <= 1'b0;
            corrected <= 1'b0;
            err_pos   <= 4'd0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            t   <= t_next;
            idx <= idx + 4'd1;
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_receiver.sv
// Bench for crc_receiver: vector table with a scoreboard queue, plus stall, reset-abort
// and err_count saturation sequences.
module tb_crc_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] data_out;
  logic [3:0]  syndrome;
  logic        crc_ok;
  logic        corrected;
  logic [3:0]  err_pos;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_count;

  crc_receiver dut (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .syndrome(syndrome), .crc_ok(crc_ok), .corrected(corrected),
    .err_pos(err_pos), .out_valid(out_valid), .out_ready(out_ready), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] frame;
    logic [10:0] data;
    logic [3:0]  syn;
    logic        ok;
    logic        corr;
    logic [3:0]  pos;
  } vec_t;

  vec_t tbl[18];
  vec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_checks = 0;
  int   exp_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Polynomial long division by g = x^4+x+1 (5'b10011).
  function automatic logic [3:0] poly_mod(input logic [14:0] f);
    logic [14:0] r;
    r = f;
    for (int p = 14; p >= 4; p--)
      if (r[p]) r = r ^ (15'h0013 << (p - 4));
    return r[3:0];
  endfunction

  task automatic run_frame(input vec_t v);
    int   guard;
    int   cyc;
    int   exp_lat;
    vec_t e;
    guard = 0;
    while (!in_ready && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    data_in  = v.frame;
    in_valid = 1'b1;
    exp_q.push_back(v);
    vectors++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = 15'($urandom);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("out_valid_rise", 32'(out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check("queue_nonempty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    exp_lat = e.ok ? 15 : 16 + int'(e.pos);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("data_out", 32'(data_out), 32'(e.data));
    check("syndrome", 32'(syndrome), 32'(e.syn));
    check("crc_ok", 32'(crc_ok), 32'(e.ok));
    check("corrected", 32'(corrected), 32'(e.corr));
    check("err_pos", 32'(err_pos), 32'(e.pos));
    if (e.corr && exp_err < 255) exp_err++;
    check("err_count", 32'(err_count), 32'(exp_err));
    if (out_ready) begin
      @(posedge clk);
      #1;
      check("out_valid_fall", 32'(out_valid), 32'd0);
      check("in_ready_back", 32'(in_ready), 32'd1);
      check("data_out_hold", 32'(data_out), 32'(e.data));
    end
  endtask

  initial begin
    vec_t v;
    logic [10:0] held_data;
    logic [3:0]  held_pos;
    logic        seen;

    tbl[0] = '{frame: 15'h0013, data: 11'h001, syn: 4'h0, ok: 1'b1, corr: 1'b0, pos: 4'd0};
    tbl[1] = '{frame: 15'h4009, data: 11'h400, syn: 4'h0, ok: 1'b1, corr: 1'b0, pos: 4'd0};
    tbl[2] = '{frame: 15'h0093, data: 11'h001, syn: 4'hB, ok: 1'b0, corr: 1'b1, pos: 4'd7};
    for (int i = 0; i < 15; i++) begin
      tbl[3+i].frame = 15'h4009 ^ (15'd1 << i);
      tbl[3+i].data  = 11'h400;
      tbl[3+i].syn   = poly_mod(15'h4009 ^ (15'd1 << i));
      tbl[3+i].ok    = 1'b0;
      tbl[3+i].corr  = 1'b1;
      tbl[3+i].pos   = 4'(i);
    end

    reset     = 1'b1;
    data_in   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    for (int k = 0; k < 18; k++) run_frame(tbl[k]);

    // Downstream stall: outputs hold, in_ready low, in_valid pulse ignored.
    out_ready = 1'b0;
    run_frame(tbl[6]);
    held_data = data_out;
    held_pos  = err_pos;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (c == 2);
      data_in  = 15'h0013;
      @(posedge clk);
      #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(data_out), 32'(held_data));
      check("stall_pos", 32'(err_pos), 32'(held_pos));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_valid", 32'(out_valid), 32'd0);
    check("stall_release_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("ignored_pulse_no_output", 32'(seen), 32'd0);

    // Reset during LOCATE aborts the frame.
    v = tbl[17];
    @(negedge clk);
    data_in  = v.frame;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_data_out", 32'(data_out), 32'd0);
    check("abort_syndrome", 32'(syndrome), 32'd0);
    check("abort_crc_ok", 32'(crc_ok), 32'd0);
    check("abort_corrected", 32'(corrected), 32'd0);
    check("abort_err_pos", 32'(err_pos), 32'd0);
    check("abort_err_count", 32'(err_count), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    exp_err = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_rel_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_output", 32'(seen), 32'd0);
    run_frame(tbl[2]);

    // err_count saturation.
    for (int n = 0; n < 260; n++) run_frame(tbl[2]);
    check("err_count_sat", 32'(err_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crc_receiver.md
# crc_receiver

Receive-side CRC checker and single-bit corrector for the 15-bit CRC-4 frames produced by the transmit path. A frame is 11 data bits in [14:4] and a 4-bit CRC in [3:0]. The generator polynomial is x^4+x+1, which makes the frame a cyclic Hamming(15,11) code. The block computes the syndrome serially, locates and flips a single erroneous bit, and hands the corrected data word downstream over a valid/ready handshake.

## Interface
- No parameters; frame width 15, data width 11, CRC width 4, generator 4'b0011 (implicit x^4) are fixed.
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- data_in  input  15  received frame; bit 14 is highest-order coefficient
- in_valid  input  1  data_in valid
- in_ready  output  1  block can accept a frame; high only in IDLE
- data_out  output  11  corrected data bits (frame [14:4] after correction)
- syndrome  output  4  remainder of received frame mod g(x)
- crc_ok  output  1  syndrome was zero
- corrected  output  1  syndrome nonzero, one bit flipped
- err_pos  output  4  flipped bit index 0..14; 0 when crc_ok
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  downstream accepts result
- err_count  output  8  saturating count of corrected frames since reset

## Operation
- States: IDLE, CALC, LOCATE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, capture data_in into frame register, clear rem=0 and cnt=0, go to CALC.
- CALC:
  - Each cycle, bit b=frame[14-cnt] is processed MSB first.
  - rem <= {rem[2:0], b} ^ (rem[3] ? 4'b0011 : 4'b0000); cnt increments.
  - After the cycle with cnt=14, the updated rem is the syndrome.
  - If the syndrome is zero: crc_ok=1, go to OUT.
  - Else: t=4'b0001, idx=0, go to LOCATE.
- LOCATE:
  - Each cycle compare t with the syndrome.
  - On match, flip frame[idx], set err_pos=idx and corrected=1, increment err_count (saturate at 255), go to OUT.
  - On no match: t <= {t[2:0],1'b0} ^ (t[3] ? 4'b0011 : 0); idx increments.
  - g is primitive, so every nonzero syndrome matches at some idx≤14. The idx counter still stops at 14 as a guard.
- OUT:
  - out_valid=1; data_out=frame[14:4], syndrome, crc_ok, corrected and err_pos stable.
  - On out_ready, go to IDLE.
- Double-bit errors alias to a wrong single-bit correction. This is accepted behaviour; no detection beyond the syndrome is required.
- in_valid outside IDLE is ignored. The frame is captured once; data_in may change after acceptance.

## Timing
- Reset values: in_ready=0 while reset is asserted, 1 in the first cycle after release. All other outputs are 0, err_count=0, state IDLE.
- Accept edge = E0. CALC occupies edges E1..E15.
- Clean frame: out_valid is high after E15 (15-cycle latency).
- Error at bit i: LOCATE compares on edges E16..E16+i. out_valid is high after E16+i (16+i cycles).
- out_valid stays high with all outputs stable while out_ready=0.
- The handshake completes on the edge where out_valid && out_ready; out_valid falls and in_ready rises after that edge.
- Minimum frame-to-frame spacing is 17 cycles: accept, 15 CALC, 1 OUT.
- Result outputs hold their last values in IDLE, except out_valid=0. They are overwritten at the next completion.
- Reset asserted mid-CALC, LOCATE or OUT aborts the frame immediately. Nothing is emitted and err_count clears.
- err_count increments on the LOCATE match edge only, at most once per frame, never past 255.

## Test plan
- Clean frame: data_in=15'h0013, out_ready=1 -> out_valid 15 cycles after accept, data_out=11'h001, syndrome=0, crc_ok=1, corrected=0.
- Clean high frame: data_in=15'h4009 -> data_out=11'h400, crc_ok=1.
- Single error: data_in=15'h0093 (bit 7 flipped in 15'h0013) -> syndrome=4'b1011, err_pos=7, corrected=1, data_out=11'h001, out_valid 23 cycles after accept, err_count=1.
- Sweep: flip each bit 0..14 of 15'h4009 -> data_out=11'h400, err_pos equals the flipped index, latency 16+i. Then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, an in_valid pulse is ignored.
- Saturation: 260 single-error frames -> err_count=255.
- Reset: assert reset during LOCATE -> out_valid never rises for that frame, all outputs 0, next frame processed normally.
